// File: rtl/decomp_pipe_ctrl_pkg.sv
// Shared constants and state encoding for the QR decomposition pipeline sequencer.
package decomp_pipe_ctrl_pkg;

  // Default build-time geometry of the decompose pipeline.
  localparam int DECOMP_DEPTH     = 8;
  localparam int DECOMP_STAGE_CYC = 16;
  localparam int DECOMP_TAG_WL    = 4;
  localparam int DECOMP_CNT_WL    = 5;

  // Width of the occupancy count (holds 0..DEPTH for DEPTH up to 15).
  localparam int OCC_W = 4;

  // Sequencer state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_STALL = 2'd2;

endpackage

// File: rtl/decomp_slot_track.sv
// Per-level valid bit and frame tag shift register with output consume and popcount.
module decomp_slot_track
  import decomp_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = DECOMP_DEPTH,
  parameter int TAG_W = DECOMP_TAG_WL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             load_vld,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             consume,
  output logic [DEPTH-1:0] vld,
  output logic [TAG_W-1:0] out_tag,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0][TAG_W-1:0] tag;

  // Shift all levels on advance; otherwise a consumed output frame empties the last level.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      vld <= '0;
      tag <= '0;
    end else if (shift) begin
      vld <= {vld[DEPTH-2:0], load_vld};
      tag <= {tag[DEPTH-2:0], load_tag};
    end else if (consume) begin
      vld[DEPTH-1] <= 1'b0;
    end
  end

  assign out_tag = tag[DEPTH-1];

  // Count occupied levels.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(vld[i]);
    end
  end

endmodule

// File: rtl/decomp_pipe_ctrl.sv
// Sequencer for the QR decomposition pipeline: advance enable, stage-start pulse,
// level valid/tag tracking and input/output handshakes with backpressure stalling.
module decomp_pipe_ctrl
  import decomp_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH        = DECOMP_DEPTH,
  parameter int STAGE_CYCLES = DECOMP_STAGE_CYC,
  parameter int TAG_W        = DECOMP_TAG_WL,
  parameter int CNT_W        = DECOMP_CNT_WL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             adv,
  output logic             stage_start,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic [3:0]       occupancy,
  output logic             busy
);

  logic [DEPTH-1:0] vld;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             live;
  logic             step_ok;
  logic             term;
  logic             step_fire;
  logic             fire;
  logic             consume;
  logic             any_next;

  // Advance decision and handshake qualifiers; step_fire never looks at in_valid,
  // so in_ready outside IDLE is independent of the producer.
  always_comb begin
    live      = rst && !flush;
    step_ok   = !vld[DEPTH-1] || out_ready;
    term      = (cnt == CNT_W'(STAGE_CYCLES - 1));
    step_fire = 1'b0;
    case (state)
      ST_RUN:   step_fire = term && step_ok;
      ST_STALL: step_fire = step_ok;
      default:  step_fire = 1'b0;
    endcase
    fire     = live && (step_fire || (state == ST_IDLE && in_valid));
    in_ready = live && (step_fire || state == ST_IDLE);
    consume  = live && vld[DEPTH-1] && out_ready && !fire;
    any_next = in_valid || (|vld[DEPTH-2:0]);
  end

  assign adv       = fire;
  assign out_valid = rst && vld[DEPTH-1];
  assign busy      = (state != ST_IDLE);

  // FSM and per-advance step counter; an advance always restarts the count.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (fire) begin
      cnt   <= '0;
      state <= any_next ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (term) state <= ST_STALL;
          else      cnt   <= cnt + CNT_W'(1);
        end
        ST_STALL: state <= ST_STALL;
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stage-start is the advance enable delayed by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) stage_start <= 1'b0;
    else      stage_start <= adv;
  end

  decomp_slot_track #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .shift     (fire),
    .load_vld  (in_valid),
    .load_tag  (in_tag),
    .consume   (consume),
    .vld       (vld),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_decomp_pipe_ctrl.sv
// Bench for decomp_pipe_ctrl: directed table, multi-cycle corner sequences and
// randomized traffic against a behavioural model plus an in-order scoreboard.
module tb_decomp_pipe_ctrl;

  localparam int DEPTH = 8;
  localparam int SC    = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b0;
  logic             in_ready, adv, stage_start, out_valid, busy;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decomp_pipe_ctrl #(
    .DEPTH        (DEPTH),
    .STAGE_CYCLES (SC),
    .TAG_W        (TAG_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_tag      (in_tag),
    .in_ready    (in_ready),
    .adv         (adv),
    .stage_start (stage_start),
    .out_valid   (out_valid),
    .out_tag     (out_tag),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .busy        (busy)
  );

  // Behavioural model: levels as an array, a phase counting cycles since the last
  // advance (saturating at SC-1 while waiting for the consumer), and an idle flag.
  bit m_v[DEPTH];
  int m_t[DEPTH];
  bit m_idle;
  int m_phase;
  bit m_ss;
  bit mdl_on = 1'b0;
  bit m_acc;
  int sb_q[$];

  typedef struct {
    bit r; bit f; bit iv; int tg; bit ordy;
    int adv; int ir; int ov; int occ; int busy; int ss;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0;
      m_t[k] = 0;
    end
    m_idle  = 1'b1;
    m_phase = 0;
    m_ss    = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive inputs after the falling edge, check just before the rising edge,
  // then move the model across that edge.
  task automatic cycle(input bit r, input bit f, input bit iv, input int tg, input bit ordy);
    bit sok, rdy_step, any;
    int e_adv, e_ir, e_ov, e_occ, exp_tag;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_tag = TAG_W'(tg); out_ready = ordy;
    #1;
    m_acc = 1'b0;
    if (mdl_on) begin
      sok      = !m_v[DEPTH-1] || ordy;
      rdy_step = !m_idle && (m_phase == SC - 1) && sok;
      if (!r) begin
        e_adv = 0; e_ir = 0; e_ov = 0;
      end else begin
        e_ir  = int'(!f && (m_idle || rdy_step));
        e_adv = int'(!f && (m_idle ? iv : rdy_step));
        e_ov  = int'(m_v[DEPTH-1]);
      end
      e_occ = 0;
      for (int k = 0; k < DEPTH; k++) e_occ += int'(m_v[k]);
      chk("adv", int'(adv), e_adv);
      chk("in_ready", int'(in_ready), e_ir);
      chk("out_valid", int'(out_valid), e_ov);
      chk("occupancy", int'(occupancy), e_occ);
      chk("busy", int'(busy), int'(!m_idle));
      chk("stage_start", int'(stage_start), int'(m_ss));
      if (e_ov == 1) chk("out_tag", int'(out_tag), m_t[DEPTH-1]);
      // Scoreboard: accepted frames must leave in order with their tags.
      if (r && !f) begin
        if (e_ov == 1 && ordy) begin
          if (sb_q.size() == 0) chk("sb_nonempty", 0, 1);
          else begin
            exp_tag = sb_q.pop_front();
            chk("sb_order", int'(out_tag), exp_tag);
          end
        end
        if (iv && e_ir == 1) begin
          sb_q.push_back(tg & 15);
          m_acc = 1'b1;
        end
      end
      // Edge update.
      if (!r || f) begin
        model_clear();
      end else if (e_adv == 1) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          m_v[k] = m_v[k-1];
          m_t[k] = m_t[k-1];
        end
        m_v[0]  = iv;
        m_t[0]  = tg & 15;
        m_phase = 0;
        any     = 1'b0;
        for (int k = 0; k < DEPTH; k++) any |= m_v[k];
        m_idle  = !any;
        m_ss    = 1'b1;
      end else begin
        if (e_ov == 1 && ordy) m_v[DEPTH-1] = 1'b0;
        if (!m_idle && m_phase < SC - 1) m_phase++;
        m_ss = 1'b0;
      end
    end
  endtask

  initial begin
    int first_ov, tag_at_ov, tg;

    // Directed table: {rst, flush, in_valid, in_tag, out_ready | adv, in_ready, out_valid, occupancy, busy, stage_start}
    tbl[0]  = '{0, 0, 1, 5, 1,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 5, 1,  1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 6, 1,  0, 0, 0, 1, 1, 1};
    tbl[4]  = '{1, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 1, 1, 6, 1,  0, 0, 0, 1, 1, 0};
    tbl[6]  = '{1, 0, 1, 7, 1,  1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0};

    cycle(0, 0, 0, 0, 0);
    model_clear();
    mdl_on = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].tg, tbl[i].ordy);
      chk($sformatf("tbl%0d_adv", i), int'(adv), tbl[i].adv);
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), tbl[i].ir);
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), tbl[i].ov);
      chk($sformatf("tbl%0d_occ", i), int'(occupancy), tbl[i].occ);
      chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("tbl%0d_stage_start", i), int'(stage_start), tbl[i].ss);
    end

    // Single frame latency: accepted at cycle 0, output expected at cycle 113.
    cycle(1, 0, 1, 3, 1);
    chk("lat_adv_at_accept", int'(adv), 1);
    first_ov  = -1;
    tag_at_ov = -1;
    for (int k = 1; k <= 200; k++) begin
      cycle(1, 0, 0, 0, 1);
      if (k == 1) chk("lat_stage_start", int'(stage_start), 1);
      if (out_valid && first_ov < 0) begin
        first_ov  = k;
        tag_at_ov = int'(out_tag);
      end
    end
    chk("lat_cycles", first_ov, 1 + (DEPTH - 1) * SC);
    chk("lat_tag", tag_at_ov, 3);
    chk("lat_idle_busy", int'(busy), 0);
    chk("lat_idle_occ", int'(occupancy), 0);

    // Fill with backpressure until stalled.
    tg = 0;
    for (int k = 0; k < 150; k++) begin
      cycle(1, 0, 1, tg, 0);
      if (m_acc) tg++;
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 1, tg, 0);
      chk("stall_adv", int'(adv), 0);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_occ", int'(occupancy), DEPTH);
      chk("stall_out_tag", int'(out_tag), 0);
    end
    cycle(1, 0, 1, tg, 1);
    chk("release_adv", int'(adv), 1);
    chk("release_in_ready", int'(in_ready), 1);
    if (m_acc) tg++;
    cycle(1, 0, 1, tg, 1);
    chk("release_out_valid", int'(out_valid), 1);
    chk("release_next_tag", int'(out_tag), 1);
    if (m_acc) tg++;

    // Flush with frames in flight, then immediate re-accept.
    for (int k = 0; k < 23; k++) begin
      cycle(1, 0, 1, tg, 1);
      if (m_acc) tg++;
    end
    cycle(1, 1, 1, tg, 1);
    chk("flush_adv", int'(adv), 0);
    cycle(1, 0, 1, 9, 1);
    chk("flush_occ", int'(occupancy), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_reaccept_ready", int'(in_ready), 1);
    chk("flush_reaccept_adv", int'(adv), 1);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decomp_pipe_ctrl.md
Name: decomp_pipe_ctrl

Overview:
Sequencer for the 8-level QR decomposition pipeline (input register, six inter-stage registers, output register around the seven decompose stages).
- Issues the single-cycle pipeline-advance enable that clocks all pipeline registers.
- Issues the stage-start pulse that restarts every iterative stage.
- Tracks a valid bit and a frame tag per register level.
- Provides valid/ready handshakes at the H/Y input and at the R/Y/colorder output, with backpressure-driven stalling.

Parameters:
DEPTH, 8, number of pipeline register levels tracked (input reg + 6 inter-stage + output reg)
STAGE_CYCLES, 16, clk cycles each decompose stage needs per advance (must be >= 2)
TAG_W, 4, frame tag width carried alongside each level
CNT_W, 5, step counter width; must hold STAGE_CYCLES-1

Ports:
clk  in  1  single system clock
rst  in  1  synchronous active-low reset
flush  in  1  synchronous pipeline clear, priority over all but rst
in_valid  in  1  H/Y frame presented on datapath input
in_tag  in  TAG_W  tag of presented frame
in_ready  out  1  frame accepted this cycle when in_valid&&in_ready
adv  out  1  pipeline-advance enable; all pipeline registers load when high
stage_start  out  1  registered adv; stages begin computation
out_valid  out  1  output register holds a finished frame
out_tag  out  TAG_W  tag of frame in output register
out_ready  in  1  consumer takes output frame
occupancy  out  4  popcount of level valid bits (0..DEPTH)
busy  out  1  state != IDLE

Behaviour:
Reset and flush:
- rst low at clk edge: vld[0..DEPTH-1]=0, tags=0, cnt=0, state=IDLE, stage_start=0.
- Combinational outputs adv, in_ready and out_valid are forced 0 while rst is low.
- flush: same clearing as rst on the next edge; adv is suppressed in the flush cycle; in-flight frames are dropped and no out handshake completes.

States: IDLE, RUN, STALL.
- IDLE (all vld=0):
  - in_ready=1, adv=in_valid, cnt held 0.
  - On in_valid: vld[0]<=1, tag[0]<=in_tag, go RUN with cnt<=0.
- RUN:
  - cnt increments every cycle.
  - At cnt==STAGE_CYCLES-1: if step_ok then fire, else go STALL with cnt held.
- STALL:
  - Fire as soon as step_ok, then go RUN.
- step_ok = !vld[DEPTH-1] || out_ready.

Fire cycle:
- adv=1, in_ready=1, cnt<=0.
- vld[k]<=vld[k-1] and tag[k]<=tag[k-1] for k>=1.
- vld[0]<=in_valid, tag[0]<=in_tag.
- If every post-shift vld is 0, go IDLE; otherwise go RUN.
- in_ready is never high outside IDLE or a fire cycle.
- in_ready does not depend on in_valid (in RUN/STALL it depends only on cnt, state, vld[DEPTH-1] and out_ready).

Output handshake:
- out_valid=vld[DEPTH-1], out_tag=tag[DEPTH-1].
- out_valid&&out_ready without fire clears vld[DEPTH-1].
- With simultaneous fire, the shift-in value wins; the old frame counts as consumed.

Bubbles and timing:
- Bubbles advance normally (an empty vld[0] still shifts).
- stage_start is adv delayed exactly 1 cycle.
- Latency: frame accepted at cycle t gives out_valid at t+1+(DEPTH-1)*STAGE_CYCLES when there is no stall (defaults: t+113).
- Steady-state throughput: 1 frame per STAGE_CYCLES.

Counter and occupancy:
- cnt never exceeds STAGE_CYCLES-1.
- cnt is cleared on every fire, in IDLE and on flush.
- occupancy is combinational from vld.

Decomposition:
- parameters.v gains `DECOMP_DEPTH, `DECOMP_STAGE_CYC and `DECOMP_TAG_WL; the wrapper passes them as parameters.
- Sub-module decomp_slot_track: DEPTH-level valid+tag shift register with shift-enable, load-in, output-consume and clear inputs, and a popcount output.
- decomp_pipe_ctrl holds the FSM, the counter and the handshake logic.

Test Plan:
- Reset, then one frame tag=3 at cycle 10 with out_ready=1 -> adv at 10; stage_start at 11; out_valid with out_tag=3 at cycle 123; then IDLE, occupancy=0.
- in_valid held, tags 0..9, out_ready=1 -> accepts exactly every 16 cycles; occupancy saturates at 8; outputs appear in tag order with no gaps.
- Full pipe with out_ready=0 at terminal count -> STALL; adv=0, in_ready=0, cnt held at 15; out_ready=1 three cycles later -> fire that same cycle and the next tag appears.
- flush at cnt=7 with 5 frames in flight -> next cycle occupancy=0, out_valid=0, state IDLE; a following in_valid is accepted immediately.
- rst low for 1 cycle mid-RUN -> all outputs 0 on the next edge; no adv until a new in_valid arrives.
- out_valid with out_ready=1 in the fire cycle while vld[DEPTH-2]=1 -> out_valid stays 1 with the new tag; no frame is duplicated or lost.
